// File: rtl/add64_seq.sv
`default_nettype none
// ============================================================================
// Module   : add64_seq
// Brief    : 2*HALF_W-bit add sequenced over two passes of an external adder.
// Revision : 1.0
// ============================================================================

module add64_seq #(
  parameter int HALF_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2*HALF_W-1:0] a_in,
  input  logic [2*HALF_W-1:0] b_in,
  input  logic                cin_in,
  output logic [HALF_W-1:0]   add_a,
  output logic [HALF_W-1:0]   add_b,
  output logic                add_cin,
  input  logic [HALF_W-1:0]   add_sum,
  input  logic                add_cout,
  output logic                ready,
  output logic [2*HALF_W-1:0] result,
  output logic                cout,
  output logic                zero,
  output logic                ovf,
  output logic                done
);

  localparam int FULL_W = 2 * HALF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [FULL_W-1:0]   a_q, a_d;
  logic [FULL_W-1:0]   b_q, b_d;
  logic                cin_q, cin_d;
  logic                carry_q, carry_d;
  logic [FULL_W-1:0]   result_q, result_d;
  logic                cout_q, cout_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          cin_d    = cin_in;
          carry_d  = 1'b0;
          result_d = '0;
          cout_d   = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_LOW;
        end
      end

      S_LOW: begin
        add_a                  = a_q[HALF_W-1:0];
        add_b                  = b_q[HALF_W-1:0];
        add_cin                = cin_q;
        result_d[HALF_W-1:0]   = add_sum;
        carry_d                = add_cout;
        state_d                = S_HIGH;
      end

      S_HIGH: begin
        add_a                   = a_q[FULL_W-1:HALF_W];
        add_b                   = b_q[FULL_W-1:HALF_W];
        add_cin                 = carry_q;
        result_d[FULL_W-1:HALF_W] = add_sum;
        cout_d                  = add_cout;
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        ovf_d   = (a_q[FULL_W-1] == b_q[FULL_W-1]) &&
                  (add_sum[HALF_W-1] != a_q[FULL_W-1]);
        zero_d  = (add_sum == '0) && (result_q[HALF_W-1:0] == '0);
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next-state decode.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire
